// File: rtl/boss_hp_pkg.sv
// Shared game constants and types for the boss blocks (hit points, hitbox, FSM states).
package boss_hp_pkg;

  localparam int unsigned COORD_W      = 10;
  localparam int unsigned HP_W         = 10;
  localparam int unsigned BOSS_HP_INIT = 450;
  localparam int unsigned PHASE_HI     = 300;
  localparam int unsigned PHASE_LO     = 150;
  localparam int unsigned BOSS_HIT_W   = 64;
  localparam int unsigned BOSS_HIT_H   = 48;

  typedef enum logic [1:0] {
    ST_ARMED  = 2'd0,
    ST_FIGHT  = 2'd1,
    ST_IFRAME = 2'd2,
    ST_DEAD   = 2'd3
  } boss_state_e;

  // Fight phase from hit points: 0 above PHASE_HI, 3 once the boss is at zero.
  function automatic logic [1:0] hp_phase(input logic [HP_W-1:0] hp);
    logic [1:0] ph;
    if (hp == '0)                          ph = 2'd3;
    else if (hp <= HP_W'(PHASE_LO))        ph = 2'd2;
    else if (hp <= HP_W'(PHASE_HI))        ph = 2'd1;
    else                                   ph = 2'd0;
    return ph;
  endfunction

endpackage

// File: rtl/boss_hp_box_hit.sv
// Point-in-box test; box end is computed one bit wider so boxes near the screen edge never wrap.
module box_hit
  import boss_hp_pkg::*;
(
  input  logic [COORD_W-1:0] px_i,
  input  logic [COORD_W-1:0] py_i,
  input  logic [COORD_W-1:0] bx_i,
  input  logic [COORD_W-1:0] by_i,
  input  logic [COORD_W-1:0] bw_i,
  input  logic [COORD_W-1:0] bh_i,
  output logic               hit_c_o
);

  logic [COORD_W:0] x_end_c;
  logic [COORD_W:0] y_end_c;

  assign x_end_c = {1'b0, bx_i} + {1'b0, bw_i};
  assign y_end_c = {1'b0, by_i} + {1'b0, bh_i};

  assign hit_c_o = (px_i >= bx_i) && ({1'b0, px_i} < x_end_c) &&
                   (py_i >= by_i) && ({1'b0, py_i} < y_end_c);

endmodule

// File: rtl/boss_hp.sv
// Boss hit-point tracker: accepts bullet hits, runs invulnerability frames and reports phase/death.
module boss_hp
  import boss_hp_pkg::*;
#(
  parameter int unsigned HP_INIT = BOSS_HP_INIT,
  parameter int unsigned DMG     = 10,
  parameter int unsigned BOSS_W  = BOSS_HIT_W,
  parameter int unsigned BOSS_H  = BOSS_HIT_H,
  parameter int unsigned IFRAMES = 4
) (
  input  logic               clk22,
  input  logic               rst_n,
  input  logic               restart,
  input  logic               boss,
  input  logic [COORD_W-1:0] bossx,
  input  logic [COORD_W-1:0] bossy,
  input  logic               bul_valid,
  input  logic [COORD_W-1:0] bulx,
  input  logic [COORD_W-1:0] buly,
  output logic [HP_W-1:0]    bosshp,
  output logic               hit,
  output logic               flash,
  output logic [1:0]         phase,
  output logic               boss_dead
);

  localparam int unsigned CNT_W = (IFRAMES > 1) ? $clog2(IFRAMES) : 1;

  boss_state_e       state_q, state_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic              flash_q, flash_d;
  logic              dead_q, dead_d;
  logic [1:0]        phase_q, phase_d;
  logic              in_box_c;
  logic              overlap_c;
  logic [HP_W-1:0]   hp_after_c;

  box_hit u_box_hit (
    .px_i    (bulx),
    .py_i    (buly),
    .bx_i    (bossx),
    .by_i    (bossy),
    .bw_i    (COORD_W'(BOSS_W)),
    .bh_i    (COORD_W'(BOSS_H)),
    .hit_c_o (in_box_c)
  );

  assign overlap_c  = bul_valid && boss && in_box_c;
  assign hp_after_c = (hp_q > HP_W'(DMG)) ? (hp_q - HP_W'(DMG)) : '0;

  always_ff @(posedge clk22 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ARMED;
      hp_q    <= HP_W'(HP_INIT);
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      flash_q <= 1'b0;
      dead_q  <= 1'b0;
      phase_q <= hp_phase(HP_W'(HP_INIT));
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      flash_q <= flash_d;
      dead_q  <= dead_d;
      phase_q <= phase_d;
    end
  end

  // Next state; with boss off-screen the fight and its i-frame countdown are frozen.
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    hit_d   = 1'b0;
    if (restart) begin
      state_d = ST_ARMED;
      hp_d    = HP_W'(HP_INIT);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ARMED: begin
          hp_d = HP_W'(HP_INIT);
          if (boss) state_d = ST_FIGHT;
        end
        ST_FIGHT: begin
          if (overlap_c) begin
            hit_d   = 1'b1;
            hp_d    = hp_after_c;
            cnt_d   = CNT_W'(IFRAMES - 1);
            state_d = (hp_after_c != '0) ? ST_IFRAME : ST_DEAD;
          end
        end
        ST_IFRAME: begin
          if (boss) begin
            if (cnt_q == '0) state_d = ST_FIGHT;
            else             cnt_d   = cnt_q - CNT_W'(1);
          end
        end
        ST_DEAD: begin
          hp_d = '0;
        end
        default: state_d = ST_ARMED;
      endcase
    end
    flash_d = (state_d == ST_IFRAME);
    dead_d  = (state_d == ST_DEAD);
    phase_d = hp_phase(hp_d);
  end

  assign bosshp    = hp_q;
  assign hit       = hit_q;
  assign flash     = flash_q;
  assign phase     = phase_q;
  assign boss_dead = dead_q;

endmodule

// File: tb/tb_boss_hp.sv
// Directed bench for boss_hp: two instances (full and low HP) checked against a cycle scoreboard.
module tb_boss_hp;

  localparam int HP_A  = 450;
  localparam int HP_B  = 25;
  localparam int BW    = 64;
  localparam int BH    = 48;
  localparam int DMG   = 10;
  localparam int IFR   = 4;

  logic       clk22 = 1'b0;
  logic       rst_n, restart, boss, bul_valid;
  logic [9:0] bossx, bossy, bulx, buly;
  logic [9:0] hp_a, hp_b;
  logic       hit_a, hit_b, flash_a, flash_b, dead_a, dead_b;
  logic [1:0] ph_a, ph_b;

  always #5 clk22 = ~clk22;

  boss_hp u_dut (
    .clk22(clk22), .rst_n(rst_n), .restart(restart), .boss(boss),
    .bossx(bossx), .bossy(bossy), .bul_valid(bul_valid), .bulx(bulx), .buly(buly),
    .bosshp(hp_a), .hit(hit_a), .flash(flash_a), .phase(ph_a), .boss_dead(dead_a)
  );

  boss_hp #(.HP_INIT(HP_B)) u_dut_low (
    .clk22(clk22), .rst_n(rst_n), .restart(restart), .boss(boss),
    .bossx(bossx), .bossy(bossy), .bul_valid(bul_valid), .bulx(bulx), .buly(buly),
    .bosshp(hp_b), .hit(hit_b), .flash(flash_b), .phase(ph_b), .boss_dead(dead_b)
  );

  typedef struct {
    int hp;
    bit armed;
    bit dead;
    int lock;
    bit hit;
  } mdl_t;

  typedef struct {
    bit hit;
    int hp;
    bit flash;
    int phase;
    bit dead;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  mdl_t ma, mb;
  int   n_vec = 0;
  int   n_err = 0;

  function automatic mdl_t m_reset(int init);
    mdl_t s;
    s.hp = init; s.armed = 1'b1; s.dead = 1'b0; s.lock = 0; s.hit = 1'b0;
    return s;
  endfunction

  // lock counts the flash-high cycles still to be seen after the coming edge.
  function automatic mdl_t m_next(mdl_t s, int init, bit rs, bit bo, bit ov);
    mdl_t n = s;
    n.hit = 1'b0;
    if (rs) n = m_reset(init);
    else if (s.armed) begin
      if (bo) n.armed = 1'b0;
    end else if (s.dead) begin
      n.hp = 0;
    end else if (s.lock > 0) begin
      if (bo) n.lock = s.lock - 1;
    end else if (ov) begin
      n.hit = 1'b1;
      n.hp  = (s.hp > DMG) ? s.hp - DMG : 0;
      if (n.hp == 0) n.dead = 1'b1;
      else           n.lock = IFR;
    end
    return n;
  endfunction

  function automatic exp_t m_exp(mdl_t s);
    exp_t e;
    e.hit = s.hit; e.hp = s.hp; e.flash = (s.lock > 0); e.dead = s.dead;
    if (s.hp == 0)        e.phase = 3;
    else if (s.hp <= 150) e.phase = 2;
    else if (s.hp <= 300) e.phase = 1;
    else                  e.phase = 0;
    return e;
  endfunction

  function automatic bit geom();
    int bx = int'(bossx);
    int by = int'(bossy);
    int x  = int'(bulx);
    int y  = int'(buly);
    return bul_valid && boss && (x >= bx) && (x < bx + BW) && (y >= by) && (y < by + BH);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_out(input string tag);
    exp_t ea, eb;
    ea = q_a.pop_front();
    eb = q_b.pop_front();
    chk({tag, ".a.hit"},   32'(hit_a),   32'(ea.hit));
    chk({tag, ".a.hp"},    32'(hp_a),    32'(ea.hp));
    chk({tag, ".a.flash"}, 32'(flash_a), 32'(ea.flash));
    chk({tag, ".a.phase"}, 32'(ph_a),    32'(ea.phase));
    chk({tag, ".a.dead"},  32'(dead_a),  32'(ea.dead));
    chk({tag, ".b.hit"},   32'(hit_b),   32'(eb.hit));
    chk({tag, ".b.hp"},    32'(hp_b),    32'(eb.hp));
    chk({tag, ".b.flash"}, 32'(flash_b), 32'(eb.flash));
    chk({tag, ".b.phase"}, 32'(ph_b),    32'(eb.phase));
    chk({tag, ".b.dead"},  32'(dead_b),  32'(eb.dead));
  endtask

  task automatic tick(input string tag);
    bit ov;
    ov = geom();
    ma = m_next(ma, HP_A, restart, boss, ov);
    mb = m_next(mb, HP_B, restart, boss, ov);
    q_a.push_back(m_exp(ma));
    q_b.push_back(m_exp(mb));
    @(posedge clk22);
    #1;
    cmp_out(tag);
  endtask

  task automatic ticks(input string tag, input int n);
    for (int i = 0; i < n; i++) tick(tag);
  endtask

  task automatic bullet(input bit v, input int x, input int y);
    bul_valid = v;
    bulx      = 10'(x);
    buly      = 10'(y);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".a.hp"},    32'(hp_a),    32'(HP_A));
    chk({tag, ".a.phase"}, 32'(ph_a),    32'd0);
    chk({tag, ".a.hit"},   32'(hit_a),   32'd0);
    chk({tag, ".a.flash"}, 32'(flash_a), 32'd0);
    chk({tag, ".a.dead"},  32'(dead_a),  32'd0);
    chk({tag, ".b.hp"},    32'(hp_b),    32'(HP_B));
    chk({tag, ".b.flash"}, 32'(flash_b), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; restart = 1'b0; boss = 1'b0;
    bossx = 10'd100; bossy = 10'd75;
    bullet(1'b0, 0, 0);
    ma = m_reset(HP_A);
    mb = m_reset(HP_B);
    #12;
    chk_reset("reset");
    @(posedge clk22); #1;
    rst_n = 1'b1;

    // Boss appears, no bullet: ARMED -> FIGHT
    boss = 1'b1;
    tick("arm");
    ticks("idle", 2);

    // Single-cycle bullet inside the box
    bullet(1'b1, 120, 80);
    tick("hit1");
    bullet(1'b0, 0, 0);
    ticks("iframe1", 6);

    // Restart then hold the bullet on the box for 10 cycles
    restart = 1'b1;
    tick("restart1");
    restart = 1'b0;
    tick("rearm");
    bullet(1'b1, 120, 80);
    ticks("hold", 10);
    bullet(1'b0, 0, 0);
    ticks("hold_off", 2);

    // Hitbox edge probes
    bullet(1'b1, 164, 80);
    tick("x164");
    bullet(1'b1, 163, 80);
    tick("x163");
    bullet(1'b0, 0, 0);
    ticks("x163_if", 5);
    bullet(1'b1, 120, 123);
    tick("y123");
    bullet(1'b1, 100, 122);
    tick("y122");
    bullet(1'b0, 0, 0);
    ticks("y122_if", 5);
    bossx = 10'd1000;
    bullet(1'b1, 1020, 80);
    tick("nowrap");
    bullet(1'b1, 990, 80);
    ticks("left_of_box", 5);
    bullet(1'b0, 0, 0);
    bossx = 10'd100;
    ticks("settle", 1);

    // Restart while the low-HP boss is dead, same cycle as an overlap
    bullet(1'b1, 130, 90);
    restart = 1'b1;
    tick("restart_dead");
    restart = 1'b0;
    tick("armed_overlap");
    tick("fight_hit");

    // Boss off-screen during i-frames freezes the countdown
    boss = 1'b0;
    ticks("boss_off", 3);
    boss = 1'b1;
    bullet(1'b0, 0, 0);
    ticks("boss_back", 5);

    // Asynchronous reset in the middle of i-frames
    bullet(1'b1, 130, 90);
    tick("pre_rst_hit");
    tick("pre_rst_if");
    rst_n = 1'b0;
    ma = m_reset(HP_A);
    mb = m_reset(HP_B);
    #1;
    chk_reset("rst_mid_if");
    @(posedge clk22); #1;
    chk_reset("rst_held");
    rst_n = 1'b1;
    boss = 1'b0;
    ticks("post_rst", 2);

    // Low-HP boss runs to zero from a fresh restart
    boss = 1'b1;
    restart = 1'b1;
    tick("restart2");
    restart = 1'b0;
    tick("rearm2");
    ticks("to_dead", 12);
    bullet(1'b0, 0, 0);
    ticks("dead_idle", 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
